// File: rtl/uart_io_if.sv
// CPU I/O address and strobe group for uart_io. The shared data bus is a
// resolved tristate net and is carried as a plain inout port on the device.
interface uart_io_if;
    logic [15:0] addr;
    logic        DI;
    logic        DO;

    modport master (output addr, output DI, output DO);
    modport slave  (input addr, input DI, input DO);
endinterface

// File: rtl/uart_io.sv
// Byte-serial I/O peripheral: data/status ports on the CPU I/O bus, TX FIFO
// feeding an 8N1 serialiser, and an 8N1 receiver with a one-byte holding register.
module uart_io #(
    parameter logic [15:0] BASE_ADDR    = 16'd1,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       RST_bar,
    uart_io_if.slave   cpu,
    inout  wire [15:0] bus,
    input  logic       rxd,
    output logic       txd,
    output logic       tx_busy,
    output logic       rx_ready
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // Bus decode
    logic        sel_data, sel_stat;
    logic        wr_data, wr_stat, rd_data, bus_oe;
    logic [15:0] rd_word;
    logic        unused_bus_hi;

    // TX FIFO
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           tx_full, tx_empty, fifo_pop, fifo_push;

    // TX serialiser
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    // RX path and flags
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_ready_q, rx_ready_d;
    logic        overrun_q, overrun_d;
    logic        overflow_q, overflow_d;
    logic        rx_load;

    always_comb begin
        sel_data = (cpu.addr == BASE_ADDR);
        sel_stat = (cpu.addr == STAT_ADDR);
        wr_data  = cpu.DO && sel_data;
        wr_stat  = cpu.DO && sel_stat;
        // A simultaneous DO takes priority: no read side effects, no drive
        rd_data  = cpu.DI && !cpu.DO && sel_data;
        bus_oe   = cpu.DI && !cpu.DO && (sel_data || sel_stat);
        rd_word  = sel_data ? {8'h00, rx_byte_q}
                            : {12'h000, overflow_q, overrun_q, tx_full, rx_ready_q};
    end

    assign bus           = bus_oe ? rd_word : 16'hzzzz;
    assign unused_bus_hi = ^bus[15:8];

    always_comb begin
        tx_empty  = (wr_ptr_q == rd_ptr_q);
        tx_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        fifo_pop  = (tx_state_q == S_IDLE) && !tx_empty;
        fifo_push = wr_data && (!tx_full || fifo_pop);
        wr_ptr_d  = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus[7:0];
        end
    end

    // txd is registered from the current state, so the line lags the FSM by one clk
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = 1'b1;
        unique case (tx_state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    tx_shift_d = fifo_mem[rd_ptr_q[PTR_W-1:0]];
                    tx_cnt_d   = 16'd0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load    = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_load    = rx_sync_q;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase

        rx_byte_d  = rx_load ? rx_shift_q : rx_byte_q;
        rx_ready_d = rx_ready_q;
        if (rd_data) rx_ready_d = 1'b0;
        if (rx_load) rx_ready_d = 1'b1;
        overrun_d = overrun_q;
        if (wr_stat) overrun_d = 1'b0;
        if (rx_load && rx_ready_q && !rd_data) overrun_d = 1'b1;
        overflow_d = overflow_q;
        if (wr_stat) overflow_d = 1'b0;
        if (wr_data && !fifo_push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge RST_bar) begin
        if (!RST_bar) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd      = txd_q;
    assign tx_busy  = !tx_empty || (tx_state_q != S_IDLE);
    assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_uart_io.sv
// Randomised self-checking bench for uart_io: a serial-line monitor decodes txd,
// a serial driver feeds rxd, and expectations come from a byte/flag-level model.
module tb_uart_io;
    localparam logic [15:0] BASE  = 16'd1;
    localparam logic [15:0] STAT  = 16'd2;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 4;

    logic        clk      = 1'b0;
    logic        RST_bar  = 1'b0;
    logic        rxd      = 1'b1;
    logic        txd, tx_busy, rx_ready;
    logic        tb_oe    = 1'b0;
    logic [15:0] tb_wdata = 16'h0000;
    wire  [15:0] bus;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Byte/flag-level reference model
    logic       rx_ready_m = 1'b0;
    logic       overrun_m  = 1'b0;
    logic       ovf_m      = 1'b0;
    logic [7:0] rx_byte_m  = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       framing_ok;
        int         t0;
    } frame_t;
    frame_t tx_frames[$];

    uart_io_if cpu_if();

    assign bus = tb_oe ? tb_wdata : 16'hzzzz;
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup pu (bus[gi]);
    end

    uart_io #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .RST_bar (RST_bar),
        .cpu     (cpu_if),
        .bus     (bus),
        .rxd     (rxd),
        .txd     (txd),
        .tx_busy (tx_busy),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Decodes txd frames at bit centres
    initial begin : tx_monitor
        frame_t f;
        forever begin
            @(negedge txd);
            f.t0 = cyc;
            step(CPB / 2);
            f.framing_ok = (txd == 1'b0);
            for (int b = 0; b < 8; b++) begin
                step(CPB);
                f.data[b] = txd;
            end
            step(CPB);
            f.framing_ok = f.framing_ok && txd;
            tx_frames.push_back(f);
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_if.addr = a; cpu_if.DO = 1'b1; tb_oe = 1'b1; tb_wdata = d;
        @(negedge clk);
        cpu_if.DO = 1'b0; tb_oe = 1'b0;
        $display("[TB] write addr=%0h data=%04h", a, d);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        cpu_if.addr = a; cpu_if.DI = 1'b1;
        #1 d = bus;
        @(negedge clk);
        cpu_if.DI = 1'b0;
        $display("[TB] read  addr=%0h data=%04h", a, d);
    endtask

    task automatic check_status(input string tag);
        logic [15:0] st;
        cpu_read(STAT, st);
        check(tag, st, {12'h000, ovf_m, overrun_m, 1'b0, rx_ready_m});
    endtask

    task automatic read_data(input string tag);
        logic [15:0] d;
        cpu_read(BASE, d);
        check(tag, d, {8'h00, rx_byte_m});
        rx_ready_m = 1'b0;
        check({tag, "_ready_cleared"}, rx_ready, 1'b0);
    endtask

    // DI and DO together on the status port: clears flags, bus must stay undriven
    task automatic clear_flags(input string tag);
        @(negedge clk);
        cpu_if.addr = STAT; cpu_if.DO = 1'b1; cpu_if.DI = 1'b1; tb_oe = 1'b0;
        #1 check({tag, "_no_drive"}, bus, 16'hFFFF);
        @(negedge clk);
        cpu_if.DO = 1'b0; cpu_if.DI = 1'b0;
        ovf_m = 1'b0; overrun_m = 1'b0;
        $display("[TB] clear flags");
    endtask

    task automatic wait_frames(input int n);
        int budget;
        budget = 0;
        while (tx_frames.size() < n && budget < n * 200 + 400) begin
            step(1);
            budget++;
        end
        check("frame_wait", tx_frames.size() >= n, 1'b1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (tx_busy && budget < 2000) begin
            step(1);
            budget++;
        end
        check("tx_idle_wait", tx_busy, 1'b0);
    endtask

    task automatic run_burst(input int n, input bit rnd);
        logic [7:0] sent[$];
        logic [7:0] b;
        int         accept;
        tx_frames.delete();
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'(i + 1);
            @(negedge clk);
            cpu_if.addr = BASE; cpu_if.DO = 1'b1; tb_oe = 1'b1;
            tb_wdata = {8'($urandom), b};
            sent.push_back(b);
        end
        @(negedge clk);
        cpu_if.DO = 1'b0; tb_oe = 1'b0;
        $display("[TB] burst of %0d bytes", n);
        // One byte leaves for the shifter right after the first push
        accept = (n < DEPTH + 1) ? n : DEPTH + 1;
        if (n > DEPTH + 1) ovf_m = 1'b1;
        wait_frames(accept);
        wait_idle();
        step(2 * CPB);
        check("burst_frame_count", tx_frames.size(), accept);
        for (int i = 0; i < accept && i < tx_frames.size(); i++) begin
            check($sformatf("burst%0d_byte%0d", n, i), tx_frames[i].data, sent[i]);
            check($sformatf("burst%0d_framing%0d", n, i), tx_frames[i].framing_ok, 1'b1);
            if (i > 0)
                check($sformatf("burst%0d_gap%0d", n, i),
                      tx_frames[i].t0 - tx_frames[i-1].t0, 10 * CPB + 1);
        end
        check_status($sformatf("burst%0d_status", n));
        if (ovf_m) begin
            clear_flags("burst_clear");
            check_status("burst_status_cleared");
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (rx_ready_m) overrun_m = 1'b1;
            rx_ready_m = 1'b1;
            rx_byte_m  = b;
        end
        $display("[TB] rx frame %02h stop=%0d", b, stop);
        check($sformatf("rx_ready_after_%02h", b), rx_ready, rx_ready_m);
    endtask

    initial begin
        logic [15:0] d;
        cpu_if.addr = 16'h0000; cpu_if.DI = 1'b0; cpu_if.DO = 1'b0;
        step(3);
        check("reset_txd", txd, 1'b1);
        check("reset_tx_busy", tx_busy, 1'b0);
        check("reset_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        RST_bar = 1'b1;
        check_status("reset_status");

        // Single byte 0x55: exact start-bit timing
        tx_frames.delete();
        @(negedge clk);
        cpu_if.addr = BASE; cpu_if.DO = 1'b1; tb_oe = 1'b1; tb_wdata = 16'h1A55;
        @(posedge clk);
        #1;
        cpu_if.DO = 1'b0; tb_oe = 1'b0;
        check("busy_after_push", tx_busy, 1'b1);
        check("txd_push_edge", txd, 1'b1);
        step(1);
        check("txd_plus1", txd, 1'b1);
        step(1);
        check("txd_start_fall", txd, 1'b0);
        step(CPB - 1);
        check("txd_start_end", txd, 1'b0);
        step(1);
        check("txd_bit0", txd, 1'b1);
        wait_frames(1);
        check("busy_in_stop", tx_busy, 1'b1);
        wait_idle();
        step(4);
        check("txd_after_frame", txd, 1'b1);
        check("single_frame_count", tx_frames.size(), 1);
        if (tx_frames.size() > 0) begin
            check("single_byte", tx_frames[0].data, 8'h55);
            check("single_framing", tx_frames[0].framing_ok, 1'b1);
        end

        run_burst(5, 1'b0);
        run_burst(6, 1'b0);
        for (int k = 0; k < 3; k++) run_burst($urandom_range(1, 7), 1'b1);

        // Receive path
        rx_frame(8'hA3, 1'b1);
        read_data("rx_a3");
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        check_status("rx_overrun_status");
        read_data("rx_22");
        cpu_write(STAT, 16'hFFFF);
        ovf_m = 1'b0; overrun_m = 1'b0;
        check_status("rx_flags_cleared");

        for (int k = 0; k < 8; k++) begin
            rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
            case ($urandom_range(0, 3))
                0: ;
                1: read_data("rx_rand_data");
                2: check_status("rx_rand_status");
                default: begin
                    clear_flags("rx_rand_clear");
                    check_status("rx_rand_cleared");
                end
            endcase
        end
        if (rx_ready_m) read_data("rx_drain");

        // Short low glitch must not start a byte
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        step(3 * CPB);
        check("glitch_rx_ready", rx_ready, 1'b0);
        check_status("glitch_status");

        // Reset in the middle of a frame
        cpu_write(BASE, 16'h00C3);
        cpu_write(BASE, 16'h0042);
        step(40);
        @(negedge clk);
        RST_bar = 1'b0;
        #1;
        check("midreset_txd", txd, 1'b1);
        check("midreset_busy", tx_busy, 1'b0);
        @(negedge clk);
        RST_bar = 1'b1;
        rx_ready_m = 1'b0; overrun_m = 1'b0; ovf_m = 1'b0;
        step(5);
        check("postreset_busy", tx_busy, 1'b0);
        check("postreset_txd", txd, 1'b1);
        check_status("postreset_status");
        cpu_read(16'h0005, d);
        check("unmapped_read_z", d, 16'hFFFF);
        cpu_if.addr = BASE;
        #1 check("no_di_z", bus, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_io.md
Name: uart_io

Overview:
- Byte-serial I/O peripheral on the CPU's shared 16-bit bus. It is the device that consumes the CPU's DO (device-output) strobe and answers its DI (device-input) strobe.
- Decodes two I/O addresses: a data port and a status port.
- Serialises CPU-written bytes onto txd through a small TX FIFO.
- Deserialises rxd into a one-byte receive holding register.

Parameters:
- BASE_ADDR, 16'd1: data port address; status port is BASE_ADDR+1.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥4 and even.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, all state on posedge.
- RST_bar  in  1  asynchronous active-low reset.
- addr  in  16  CPU I/O address.
- bus  inout  16  CPU data bus; driven only during a decoded DI, else high-Z.
- DI  in  1  CPU reads from device this cycle.
- DO  in  1  CPU writes to device this cycle.
- rxd  in  1  serial input, asynchronous, idle high.
- txd  out  1  serial output, idle high.
- tx_busy  out  1  TX FIFO non-empty or shifter active.
- rx_ready  out  1  received byte waiting.

Behaviour:
- Reset (RST_bar low, async): txd=1, tx_busy=0, rx_ready=0; FIFO empty; overrun=0; overflow=0; both FSMs in IDLE; bus high-Z. Reset mid-frame aborts immediately and txd returns to 1.
- Address decode:
  - sel_data = addr==BASE_ADDR.
  - sel_stat = addr==BASE_ADDR+1.
  - Other addresses: no effect, bus high-Z.
- Bus drive: combinational, zero latency. bus is driven only while DI && (sel_data || sel_stat).
  - Data read returns {8'h00, rx_byte}.
  - Status read returns {12'h000, overflow, overrun, tx_full, rx_ready}.
- DO with sel_data: at posedge, push bus[7:0] into the FIFO.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky).
- DO with sel_stat: at posedge, clear overrun and overflow. bus contents are ignored.
- DI with sel_data: at posedge, clear rx_ready.
  - If a new byte completes in the same cycle, the new byte is loaded and rx_ready stays 1.
- DI and DO both asserted in the same cycle: DO action only, bus not driven.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shifter and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit counter wraps 7→0 to exit.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE. A pop can occur on the first IDLE cycle, so back-to-back frames have no extra idle gap beyond one clk.
  - First txd falling edge occurs 2 clk after the push posedge.
- FIFO: circular, read/write pointers with one extra wrap bit.
  - full = pointers equal except the wrap bit; empty = pointers fully equal.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted.
  - tx_busy = !empty || TX FSM not IDLE.
- RX path:
  - rxd passes through a 2-flop synchroniser before use.
  - RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition enters START.
  - START: sample at CLKS_PER_BIT/2. If the sample is 1 (glitch), return to IDLE. Otherwise sample every CLKS_PER_BIT thereafter.
  - DATA: 8 samples, LSB first.
  - STOP: sample stop bit.
    - Stop bit = 1: load rx_byte and set rx_ready. If rx_ready was already 1 and not cleared this cycle, the old byte is overwritten and overrun is set.
    - Stop bit = 0 (framing error): discard the byte, flags unchanged.
    - Either way, return to IDLE after the stop sample.
- Baud counters: 16-bit, independent for TX and RX, reset to 0 on each state entry.

Test Plan:
- Reset, then DO to BASE_ADDR with bus=16'h1A55 → txd frame 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB-first, stop), each bit 16 clk. tx_busy=1 from the next posedge, 0 after the stop bit.
- Five DOs (0x01..0x05) in consecutive cycles with FIFO_DEPTH=4 → the first pops before the fifth arrives, so all five are transmitted in order, back-to-back. Status read shows overflow=0.
- Six DOs (0x01..0x06) in consecutive cycles → bytes 0x01..0x05 transmitted and 0x06 dropped, overflow=1. A DO to BASE_ADDR+1 clears it to 0.
- Drive rxd with a frame for 0xA3 at 16 clk/bit → rx_ready=1. DI at BASE_ADDR reads bus=16'h00A3, then rx_ready=0.
- Two received frames (0x11, then 0x22) with no read between → DI at BASE_ADDR+1 reads 16'h0003, data read returns 0x0022.
- 3-clk low glitch on rxd → no byte, rx_ready stays 0. Assert RST_bar low mid-TX-frame → txd=1 immediately, FIFO empty after release, DI to an unmapped address leaves bus Z.
